// File: rtl/pong_pkg.sv
// pong_pkg: shared geometry, colours, FSM state codes and small helpers for
// the pong renderer.
// Geometry is held as signed 11-bit values, so ball and paddle arithmetic
// can go below zero or past the screen edge and be detected, not wrapped.
package pong_pkg;

  localparam logic signed [10:0] H_ACTIVE   = 11'sd640;
  localparam logic signed [10:0] V_ACTIVE   = 11'sd480;
  localparam logic signed [10:0] BALL_SIZE  = 11'sd8;
  localparam logic signed [10:0] PADDLE_W   = 11'sd8;
  localparam logic signed [10:0] PADDLE_H   = 11'sd64;
  localparam logic signed [10:0] PAD_L_X    = 11'sd16;
  localparam logic signed [10:0] PAD_R_X    = 11'sd616;
  localparam logic signed [10:0] PAD_Y_MAX  = 11'sd416;
  localparam logic [9:0]         PAD_Y0     = 10'd208;
  localparam logic signed [10:0] BALL_X0    = 11'sd316;
  localparam logic signed [10:0] BALL_Y0    = 11'sd236;
  localparam logic signed [10:0] BALL_Y_MAX = 11'sd472;

  localparam logic [23:0] COL_BALL = 24'hFFFFFF;
  localparam logic [23:0] COL_LPAD = 24'hFF0000;
  localparam logic [23:0] COL_RPAD = 24'h0000FF;
  localparam logic [23:0] COL_NET  = 24'h808080;
  localparam logic [23:0] COL_BG   = 24'h000000;

  localparam logic [1:0] ST_SERVE = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_POINT = 2'd2;
  localparam logic [1:0] ST_OVER  = 2'd3;

  // 1-D interval overlap: [a, a+a_len) intersects [b, b+b_len).
  function automatic logic overlap(input logic signed [10:0] a,
                                   input logic signed [10:0] a_len,
                                   input logic signed [10:0] b,
                                   input logic signed [10:0] b_len);
    return (a < (b + b_len)) && ((a + a_len) > b);
  endfunction

  // Paddle step; both or neither button means hold; result clamped to 0..416.
  function automatic logic [9:0] paddle_next(input logic [9:0] y,
                                             input logic up,
                                             input logic dn,
                                             input logic signed [10:0] step);
    logic signed [10:0] ys;
    logic signed [10:0] nys;
    ys = $signed({1'b0, y});
    if (up && !dn) begin
      nys = ys - step;
    end else if (dn && !up) begin
      nys = ys + step;
    end else begin
      nys = ys;
    end
    if (nys < 11'sd0) begin
      nys = 11'sd0;
    end else if (nys > PAD_Y_MAX) begin
      nys = PAD_Y_MAX;
    end else begin
      nys = nys;
    end
    return 10'(nys);
  endfunction

endpackage

// File: rtl/pong_physics.sv
// pong_physics: ball motion and score FSM (SERVE -> PLAY -> POINT -> SERVE/OVER).
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   tick            one-clk frame pulse; all state changes happen on it
//   ly, ry          current left/right paddle top y (value before this tick's move)
//   bx, by          ball top-left corner, signed 11-bit
//   score_l/_r      BCD scores 0..9
//   game_over       high while in OVER
// Collision tests are made against the ball's next position (after the wall
// clamp), so a hit is seen in the same tick the ball enters a paddle.
module pong_physics
  import pong_pkg::*;
#(
  parameter int SERVE_FRAMES = 60,
  parameter int BALL_SPEED   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic [9:0]         ly,
  input  logic [9:0]         ry,
  output logic signed [10:0] bx,
  output logic signed [10:0] by,
  output logic [3:0]         score_l,
  output logic [3:0]         score_r,
  output logic               game_over
);

  localparam logic signed [10:0] BS         = 11'(BALL_SPEED);
  localparam logic [15:0]        SERVE_LAST = 16'(SERVE_FRAMES - 1);

  logic [1:0]         state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic signed [10:0] bx_q, bx_d, by_q, by_d, dx_q, dx_d, dy_q, dy_d;
  logic [3:0]         sl_q, sl_d, sr_q, sr_d;
  logic               last_left_q, last_left_d;
  logic               game_over_q, game_over_d;

  logic signed [10:0] nbx, nby, ndy, ly_s, ry_s;
  logic               hit_l, hit_r;

  assign ly_s = $signed({1'b0, ly});
  assign ry_s = $signed({1'b0, ry});

  // Next-state: candidate move with wall clamp, paddle hits, scoring, FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bx_d        = bx_q;
    by_d        = by_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    sl_d        = sl_q;
    sr_d        = sr_q;
    last_left_d = last_left_q;

    nbx = bx_q + dx_q;
    nby = by_q + dy_q;
    if (nby < 11'sd0) begin
      nby = 11'sd0;
      ndy = -dy_q;
    end else if (nby > BALL_Y_MAX) begin
      nby = BALL_Y_MAX;
      ndy = -dy_q;
    end else begin
      ndy = dy_q;
    end
    hit_l = overlap(nbx, BALL_SIZE, PAD_L_X, PADDLE_W) && overlap(nby, BALL_SIZE, ly_s, PADDLE_H);
    hit_r = overlap(nbx, BALL_SIZE, PAD_R_X, PADDLE_W) && overlap(nby, BALL_SIZE, ry_s, PADDLE_H);

    if (tick) begin
      case (state_q)
        ST_SERVE: begin
          if (cnt_q == SERVE_LAST) begin
            state_d = ST_PLAY;
            cnt_d   = 16'd0;
            dx_d    = last_left_q ? BS : -BS;
            dy_d    = BS;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        ST_PLAY: begin
          bx_d = nbx;
          by_d = nby;
          dy_d = ndy;
          if (hit_l) begin
            dx_d = BS;
          end else if (hit_r) begin
            dx_d = -BS;
          end else begin
            dx_d = dx_q;
          end
          if (nbx <= 11'sd0) begin
            sr_d        = sr_q + 4'd1;
            last_left_d = 1'b0;
            state_d     = ST_POINT;
          end else if ((nbx + BALL_SIZE) >= H_ACTIVE) begin
            sl_d        = sl_q + 4'd1;
            last_left_d = 1'b1;
            state_d     = ST_POINT;
          end else begin
            state_d = ST_PLAY;
          end
        end
        ST_POINT: begin
          if ((sl_q == 4'd9) || (sr_q == 4'd9)) begin
            state_d = ST_OVER;
          end else begin
            state_d = ST_SERVE;
            cnt_d   = 16'd0;
            bx_d    = BALL_X0;
            by_d    = BALL_Y0;
          end
        end
        ST_OVER: begin
          state_d = ST_OVER;
        end
        default: begin
          state_d = ST_SERVE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    game_over_d = (state_d == ST_OVER);
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_SERVE;
      cnt_q       <= 16'd0;
      bx_q        <= BALL_X0;
      by_q        <= BALL_Y0;
      dx_q        <= BS;
      dy_q        <= BS;
      sl_q        <= 4'd0;
      sr_q        <= 4'd0;
      last_left_q <= 1'b1;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bx_q        <= bx_d;
      by_q        <= by_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      sl_q        <= sl_d;
      sr_q        <= sr_d;
      last_left_q <= last_left_d;
      game_over_q <= game_over_d;
    end
  end

  assign bx        = bx_q;
  assign by        = by_q;
  assign score_l   = sl_q;
  assign score_r   = sr_q;
  assign game_over = game_over_q;

endmodule

// File: rtl/pong_render.sv
// pong_render: frame tick, paddle control and pixel composition for pong.
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   px, py                pixel coordinates from the VGA output stage
//   p1_up/dn, p2_up/dn    level-sensitive paddle buttons (left/right)
//   pixel                 RGB888, registered, 1 clk after px/py
//   score_l, score_r      BCD scores
//   game_over             high in OVER state
// Build option: define PONG_NET_EN to draw the dashed centre net.
// Paddles move on the same frame tick as the ball; the ball sees the paddle
// positions from before that tick's move.
module pong_render
  import pong_pkg::*;
#(
  parameter int SERVE_FRAMES = 60,
  parameter int BALL_SPEED   = 2,
  parameter int PADDLE_SPEED = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  px,
  input  logic [9:0]  py,
  input  logic        p1_up,
  input  logic        p1_dn,
  input  logic        p2_up,
  input  logic        p2_dn,
  output logic [23:0] pixel,
  output logic [3:0]  score_l,
  output logic [3:0]  score_r,
  output logic        game_over
);

  localparam logic signed [10:0] PS = 11'(PADDLE_SPEED);

  logic [9:0]         py_q;
  logic               tick_q, tick_d;
  logic [9:0]         ly_q, ly_d, ry_q, ry_d;
  logic [23:0]        pixel_q, pixel_d;
  logic signed [10:0] px_s, py_s, pyq_s, ly_s, ry_s, bx_s, by_s;
  logic               ball_on, lpad_on, rpad_on;

  assign px_s  = $signed({1'b0, px});
  assign py_s  = $signed({1'b0, py});
  assign pyq_s = $signed({1'b0, py_q});
  assign ly_s  = $signed({1'b0, ly_q});
  assign ry_s  = $signed({1'b0, ry_q});

  pong_physics #(
    .SERVE_FRAMES(SERVE_FRAMES),
    .BALL_SPEED  (BALL_SPEED)
  ) u_phys (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick_q),
    .ly       (ly_q),
    .ry       (ry_q),
    .bx       (bx_s),
    .by       (by_s),
    .score_l  (score_l),
    .score_r  (score_r),
    .game_over(game_over)
  );

  // Frame tick fires on the edge where the registered py first reaches 480.
  always_comb begin
    tick_d = (py_s == V_ACTIVE) && (pyq_s != V_ACTIVE);
  end

  // Paddle motion, only on frame ticks.
  always_comb begin
    if (tick_q) begin
      ly_d = paddle_next(ly_q, p1_up, p1_dn, PS);
      ry_d = paddle_next(ry_q, p2_up, p2_dn, PS);
    end else begin
      ly_d = ly_q;
      ry_d = ry_q;
    end
  end

  assign ball_on = !game_over && overlap(px_s, 11'sd1, bx_s, BALL_SIZE)
                              && overlap(py_s, 11'sd1, by_s, BALL_SIZE);
  assign lpad_on = overlap(px_s, 11'sd1, PAD_L_X, PADDLE_W) && overlap(py_s, 11'sd1, ly_s, PADDLE_H);
  assign rpad_on = overlap(px_s, 11'sd1, PAD_R_X, PADDLE_W) && overlap(py_s, 11'sd1, ry_s, PADDLE_H);

`ifdef PONG_NET_EN
  logic net_on;
  assign net_on = ((px == 10'd319) || (px == 10'd320)) && !py[4];
`endif

  // Pixel colour by priority; anything off the visible area is black.
  always_comb begin
    pixel_d = COL_BG;
    if ((px_s >= H_ACTIVE) || (py_s >= V_ACTIVE)) begin
      pixel_d = COL_BG;
    end else if (ball_on) begin
      pixel_d = COL_BALL;
    end else if (lpad_on) begin
      pixel_d = COL_LPAD;
    end else if (rpad_on) begin
      pixel_d = COL_RPAD;
`ifdef PONG_NET_EN
    end else if (net_on) begin
      pixel_d = COL_NET;
`endif
    end else begin
      pixel_d = COL_BG;
    end
  end

  // Pipeline, tick and paddle registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      py_q    <= 10'd0;
      tick_q  <= 1'b0;
      ly_q    <= PAD_Y0;
      ry_q    <= PAD_Y0;
      pixel_q <= COL_BG;
    end else begin
      py_q    <= py;
      tick_q  <= tick_d;
      ly_q    <= ly_d;
      ry_q    <= ry_d;
      pixel_q <= pixel_d;
    end
  end

  assign pixel = pixel_q;

endmodule

// File: tb/tb_pong_render.sv
// Self-checking bench for pong_render: directed phases plus a randomized game,
// all checked against a behavioural game model kept in integer arithmetic.
module tb_pong_render;
  import pong_pkg::*;

  localparam int SF = 60;
  localparam int BS = 2;
  localparam int PS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  px, py;
  logic        p1_up, p1_dn, p2_up, p2_dn;
  logic [23:0] pixel;
  logic [3:0]  score_l, score_r;
  logic        game_over;

  int checks = 0;
  int failures = 0;

  // model: 0 SERVE, 1 PLAY, 2 POINT, 3 OVER
  int m_state, m_cnt, m_bx, m_by, m_dx, m_dy, m_ly, m_ry, m_sl, m_sr;
  bit m_last_left;

  pong_render #(.SERVE_FRAMES(SF), .BALL_SPEED(BS), .PADDLE_SPEED(PS)) dut (
    .clk(clk), .reset(reset), .px(px), .py(py),
    .p1_up(p1_up), .p1_dn(p1_dn), .p2_up(p2_up), .p2_dn(p2_dn),
    .pixel(pixel), .score_l(score_l), .score_r(score_r), .game_over(game_over)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int st_code(input int s);
    case (s)
      0: return int'(ST_SERVE);
      1: return int'(ST_PLAY);
      2: return int'(ST_POINT);
      default: return int'(ST_OVER);
    endcase
  endfunction

  task automatic model_reset;
    m_state = 0; m_cnt = 0; m_bx = 316; m_by = 236; m_dx = BS; m_dy = BS;
    m_ly = 208; m_ry = 208; m_sl = 0; m_sr = 0; m_last_left = 1'b1;
  endtask

  function automatic int pad_move(input int y, input bit up, input bit dn);
    int n;
    n = y;
    if (up && !dn) n = y - PS;
    if (dn && !up) n = y + PS;
    if (n < 0) n = 0;
    if (n > 416) n = 416;
    return n;
  endfunction

  function automatic bit box_hit(input int x, input int y, input int pxl, input int pyt);
    return (x < pxl + 8) && (x + 8 > pxl) && (y < pyt + 64) && (y + 8 > pyt);
  endfunction

  task automatic model_step(input bit u1, input bit d1, input bit u2, input bit d2);
    int nx, ny;
    case (m_state)
      0: begin
        if (m_cnt == SF - 1) begin
          m_state = 1; m_cnt = 0; m_dx = m_last_left ? BS : -BS; m_dy = BS;
        end else m_cnt++;
      end
      1: begin
        nx = m_bx + m_dx; ny = m_by + m_dy;
        if (ny < 0) begin ny = 0; m_dy = -m_dy; end
        else if (ny + 8 > 480) begin ny = 472; m_dy = -m_dy; end
        if (box_hit(nx, ny, 16, m_ly)) m_dx = BS;
        else if (box_hit(nx, ny, 616, m_ry)) m_dx = -BS;
        if (nx <= 0) begin m_sr++; m_state = 2; m_last_left = 1'b0; end
        else if (nx + 8 >= 640) begin m_sl++; m_state = 2; m_last_left = 1'b1; end
        m_bx = nx; m_by = ny;
      end
      2: begin
        if (m_sl == 9 || m_sr == 9) m_state = 3;
        else begin m_state = 0; m_cnt = 0; m_bx = 316; m_by = 236; end
      end
      default: ;
    endcase
    m_ly = pad_move(m_ly, u1, d1);
    m_ry = pad_move(m_ry, u2, d2);
  endtask

  function automatic int model_pixel(input int x, input int y);
    if (x >= 640 || y >= 480) return 0;
    if (m_state != 3 && x >= m_bx && x < m_bx + 8 && y >= m_by && y < m_by + 8) return 'hFFFFFF;
    if (x >= 16 && x < 24 && y >= m_ly && y < m_ly + 64) return 'hFF0000;
    if (x >= 616 && x < 624 && y >= m_ry && y < m_ry + 64) return 'h0000FF;
`ifdef PONG_NET_EN
    if ((x == 319 || x == 320) && ((y / 16) % 2 == 0)) return 'h808080;
`endif
    return 0;
  endfunction

  task automatic compare_state;
    chk("ball_x", dut.u_phys.bx_q, m_bx);
    chk("ball_y", dut.u_phys.by_q, m_by);
    chk("paddle_l", dut.ly_q, m_ly);
    chk("paddle_r", dut.ry_q, m_ry);
    chk("score_l", score_l, m_sl);
    chk("score_r", score_r, m_sr);
    chk("game_over", game_over, int'(m_state == 3));
    chk("state", dut.u_phys.state_q, st_code(m_state));
    if (m_state == 0) chk("serve_cnt", dut.u_phys.cnt_q, m_cnt);
  endtask

  // One frame: py reaches 480 for one clock, then the model advances.
  task automatic frame(input bit a, input bit b, input bit c, input bit d);
    @(negedge clk);
    p1_up = a; p1_dn = b; p2_up = c; p2_dn = d;
    py = 10'd480;
    @(negedge clk);
    py = 10'd0;
    @(negedge clk);
    model_step(a, b, c, d);
    compare_state();
  endtask

  task automatic pix(input int x, input int y);
    @(negedge clk);
    px = 10'(x); py = 10'(y);
    @(negedge clk);
    chk("pixel", pixel, model_pixel(x, y));
  endtask

  task automatic pix_rand;
    int x, y;
    x = $urandom_range(0, 1023);
    y = $urandom_range(0, 600);
    if (y == 480) y = 479;
    pix(x, y);
  endtask

  task automatic pix_near;
    int x, y, rx, ry;
    rx = $urandom_range(0, 11);
    ry = $urandom_range(0, 11);
    x = m_bx + rx - 2;
    y = m_by + ry - 2;
    if (x < 0) x = 0;
    if (y < 0) y = 0;
    if (y == 480) y = 479;
    pix(x, y);
  endtask

  task automatic pick(input int y, output bit up, output bit dn);
    int r;
    r = $urandom_range(0, 9);
    if (r < 3) begin
      up = (y + 32 > m_by + 8);
      dn = (y + 32 < m_by);
    end else begin
      up = 1'($urandom_range(0, 1));
      dn = 1'($urandom_range(0, 1));
    end
  endtask

  // Reset at a falling edge; its effect is checked before any clock edge.
  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_ball_x", dut.u_phys.bx_q, 316);
    chk("rst_ball_y", dut.u_phys.by_q, 236);
    chk("rst_paddle_l", dut.ly_q, 208);
    chk("rst_score_l", score_l, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_pixel", pixel, 0);
    @(negedge clk);
    model_reset();
    compare_state();
    chk("rst_dx", dut.u_phys.dx_q, BS);
    chk("rst_dy", dut.u_phys.dy_q, BS);
    reset = 1'b0;
  endtask

  initial begin
    bit a, b, c, d;
    int n;
    reset = 1'b1; px = 10'd0; py = 10'd0;
    p1_up = 1'b0; p1_dn = 1'b0; p2_up = 1'b0; p2_dn = 1'b0;
    do_reset();

    // out-of-range pixel and left paddle pixel
    pix(100, 500);
    chk("pix_offscreen", pixel, 0);
    pix(20, 210);
    chk("pix_lpaddle", pixel, 'hFF0000);
    pix(318, 238);
    chk("pix_ball_serve", pixel, 'hFFFFFF);

    // serve and launch
    repeat (60) frame(0, 0, 0, 0);
    chk("launch_state", dut.u_phys.state_q, int'(ST_PLAY));
    frame(0, 0, 0, 0);
    chk("launch_bx", dut.u_phys.bx_q, 318);
    chk("launch_by", dut.u_phys.by_q, 238);

    // paddle clamp at top, then both buttons hold position
    repeat (60) frame(1, 0, 0, 0);
    chk("p1_top_clamp", dut.ly_q, 0);
    repeat (5) frame(0, 1, 0, 0);
    repeat (4) frame(1, 1, 0, 0);
    chk("p1_both_hold", dut.ly_q, 20);

    // reset in the middle of a frame, released with py sitting at 480
    @(negedge clk);
    py = 10'd480;
    do_reset();
    @(negedge clk);
    py = 10'd0;
    @(negedge clk);
    model_step(0, 0, 0, 0);
    compare_state();
    chk("post_rst_cnt", dut.u_phys.cnt_q, 1);

    // randomized game until someone reaches 9
    n = 0;
    while (m_state != 3 && n < 10000) begin
      pick(m_ly, a, b);
      pick(m_ry, c, d);
      frame(a, b, c, d);
      n++;
      if (n % 8 == 0) begin
        pix_near();
        pix_rand();
        pix_rand();
      end
    end
    checks++;
    if (m_state != 3) begin
      failures++;
      $error("FAIL game_end observed=%0d expected=%0d", m_state, 3);
    end

    // OVER: ball hidden, paddles still move, scores frozen
    repeat (20) begin
      frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      pix_near();
    end
    chk("over_flag", game_over, 1);

    do_reset();
    pix(319, 239);
    chk("pix_ball_after_reset", pixel, 'hFFFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pong_render.md
PONG_RENDER -- requirements
Module: pong_render

Interface
REQ-001 SHALL have parameter SERVE_FRAMES, default 60, frame ticks spent in SERVE before the ball launches.
REQ-002 SHALL have parameter BALL_SPEED, default 2, ball pixels moved per axis per frame tick.
REQ-003 SHALL have parameter PADDLE_SPEED, default 4, paddle pixels moved per frame tick.
REQ-004 SHALL have port clk  input  1  single system clock; all state is on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports px, py  input  10 each  current pixel coordinates from the VGA output stage.
REQ-007 SHALL have ports p1_up, p1_dn, p2_up, p2_dn  input  1 each  synchronous, level-sensitive paddle buttons.
REQ-008 SHALL have port pixel  output  24  RGB888 colour for (px,py), fed to the VGA output stage.
REQ-009 SHALL have ports score_l, score_r  output  4 each  BCD scores, range 0..9.
REQ-010 SHALL have port game_over  output  1  high while in OVER state.

Function
REQ-011 pixel SHALL be registered with exactly 1 clk latency from px/py.
REQ-012 pixel SHALL be 24'h000000 when px>=640 or py>=480.
REQ-013 Colour priority SHALL be ball (FFFFFF) > left paddle (FF0000) > right paddle (0000FF) > net (808080) > background (000000).
REQ-014 Ball SHALL be an 8x8 square at (bx,by); paddles SHALL be 8x64, left at x 16..23, right at x 616..623.
REQ-015 frame_tick SHALL pulse for one clk when registered py goes from !=480 to ==480; all motion updates SHALL occur only on frame_tick.
REQ-016 FSM states SHALL be SERVE, PLAY, POINT, OVER.
REQ-017 SERVE: ball at (316,236); frame count runs; after SERVE_FRAMES ticks, go to PLAY with dx=+BALL_SPEED if last point went to the left player (or after reset), else -BALL_SPEED; dy=+BALL_SPEED.
REQ-018 PLAY: each tick, bx+=dx, by+=dy; if the next by<0 or by+8>480, negate dy and clamp by inside 0..472.
REQ-019 PLAY: if the ball overlaps a paddle in both axes, dx SHALL point away from that paddle; the paddle hit takes precedence over a wall bounce in the same tick (both applied).
REQ-020 PLAY: bx<=0 SHALL increment score_r and go to POINT; bx+8>=640 SHALL increment score_l and go to POINT.
REQ-021 POINT SHALL last one frame tick, then go to OVER if any score==9, else to SERVE with the frame counter cleared.
REQ-022 OVER: ball hidden, paddles still drawn and movable, scores frozen, game_over=1; exit only by reset.
REQ-023 Paddle y SHALL move -PADDLE_SPEED on up and +PADDLE_SPEED on down; both or neither pressed SHALL mean no move; y SHALL be clamped to 0..416.
REQ-024 Ball/paddle arithmetic SHALL use signed 11-bit intermediates so that underflow is detected, not wrapped.

Reset
REQ-025 On reset: state=SERVE, frame count=0, ball at (316,236), dx=+BALL_SPEED, dy=+BALL_SPEED, both paddle y=208, scores=0, game_over=0, pixel=0.
REQ-026 Reset asserted mid-frame SHALL take effect immediately; the first frame_tick after release SHALL be counted normally.

Configuration
REQ-027 With PONG_NET_EN defined, a dashed net SHALL be drawn at px 319..320 where py[4]==0; without it, no net logic SHALL exist and those pixels SHALL be background.

Structure
REQ-028 Package pong_pkg SHALL hold H_ACTIVE=640, V_ACTIVE=480, BALL_SIZE, PADDLE_W/H, paddle x positions, colour constants and the state enum.
REQ-029 Ball/score FSM SHALL be a sub-module pong_physics; pixel composition and paddle control SHALL stay in pong_render.

Verification
REQ-030 Reset, hold all buttons low, run 61 frames -> state PLAY, ball at (318,238) one tick after launch.
REQ-031 p1_up held for 60 frames from y=208 -> left paddle y=0 and no further decrease; p1_up and p1_dn held together -> y unchanged.
REQ-032 Ball forced to by=472, dy=+2 -> next tick dy=-2, by<=472.
REQ-033 Right paddle at y=208, ball approaching at by=230 -> dx becomes -2, scores unchanged; with right paddle at y=0 -> score_l 0->1, POINT, then SERVE.
REQ-034 Drive px=100, py=500 -> pixel=000000 one clk later; px=20, py=210 -> FF0000.
REQ-035 Score reaches 9 -> game_over=1 after POINT, ball pixels absent, reset clears everything to REQ-025 values.
